booth_seq_mult_8b: RTL and testbench

- Sequential signed 8x8 Booth multiplier for the FIR datapath in cht_booth.
- Sits directly downstream of the 8-bit 2:1 operand-select mux. The mux output drives operand a; the coefficient drives operand b.
- Produces a 16-bit signed product for the accumulator stage.
- Valid/ready on both sides; one multiply in flight at a time.

---
 rtl/booth_pkg.sv | 27 ++
 rtl/booth_recode.sv | 33 +++
 rtl/booth_seq_mult_8b.sv | 110 +++++++++++
 tb/tb_booth_seq_mult_8b.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for booth_seq_mult_8b (BOOTH_RADIX4_EN selects radix-4)
package booth_pkg;

   localparam int W  = 8;
   localparam int PW = 2 * W;

`ifdef BOOTH_RADIX4_EN
   // Radix-4: two multiplier bits retired per iteration, +-2M needs one extra acc bit
   localparam int N_ITER = W / 2;
   localparam int ACC_W  = W + 2;
   localparam int WIN_W  = 3;
   localparam int SHIFT  = 2;
`else
   // Radix-2: one multiplier bit retired per iteration
   localparam int N_ITER = W;
   localparam int ACC_W  = W + 1;
   localparam int WIN_W  = 2;
   localparam int SHIFT  = 1;
`endif

   localparam int ITER_W = $clog2(N_ITER);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   typedef enum logic [2:0] {ZERO, PM, NM, P2M, N2M} booth_digit_e;

endpackage

// File: rtl/booth_recode.sv
// rtl/booth_recode.sv - Booth window recoder (2-bit radix-2 or 3-bit radix-4 under BOOTH_RADIX4_EN)
module booth_recode
   import booth_pkg::*;
(
   input  logic [WIN_W-1:0] win_i,
   output booth_digit_e     digit_o,
   output logic             sub_o,
   output logic             dbl_o
);

   // Map the multiplier window to a signed digit, then derive subtract / double controls
   always_comb begin
      digit_o = ZERO;
`ifdef BOOTH_RADIX4_EN
      case (win_i)
         3'b001, 3'b010: digit_o = PM;
         3'b011:         digit_o = P2M;
         3'b100:         digit_o = N2M;
         3'b101, 3'b110: digit_o = NM;
         default:        digit_o = ZERO;
      endcase
`else
      case (win_i)
         2'b01:   digit_o = PM;
         2'b10:   digit_o = NM;
         default: digit_o = ZERO;
      endcase
`endif
      sub_o = (digit_o == NM)  || (digit_o == N2M);
      dbl_o = (digit_o == P2M) || (digit_o == N2M);
   end

endmodule

// File: rtl/booth_seq_mult_8b.sv
// rtl/booth_seq_mult_8b.sv - sequential signed 8x8 Booth multiplier, radix-4 when BOOTH_RADIX4_EN is defined
module booth_seq_mult_8b
   import booth_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] product
);

   state_e            state_q, state_d;
   logic [ACC_W-1:0]  m_q;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [W-1:0]      q_q, q_d;
   logic              qm1_q, qm1_d;
   logic [ITER_W-1:0] iter_q;
   logic [PW-1:0]     product_q;

   logic              accept;
   logic              last_iter;
   booth_digit_e      digit;
   logic              sub;
   logic              dbl;
   logic [ACC_W-1:0]  mag;
   logic [ACC_W-1:0]  sum;
   logic [ACC_W+W:0]  shifted;

   assign accept    = in_valid && in_ready;
   assign last_iter = (state_q == CALC) && (iter_q == ITER_W'(N_ITER - 1));
   assign product   = product_q;

   // Window is the low multiplier bit(s) plus the bit shifted out last iteration
   booth_recode u_recode (
      .win_i   ({q_q[WIN_W-2:0], qm1_q}),
      .digit_o (digit),
      .sub_o   (sub),
      .dbl_o   (dbl)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = CALC;
         CALC:    if (last_iter) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   // One Booth step: add the selected multiple, then arithmetic shift of {acc,Q,q_m1}
   always_comb begin
      mag = '0;
      if (digit != ZERO) begin
         mag = dbl ? {m_q[ACC_W-2:0], 1'b0} : m_q;
      end
      sum     = sub ? (acc_q - mag) : (acc_q + mag);
      shifted = $signed({sum, q_q, qm1_q}) >>> SHIFT;
      acc_d   = shifted[ACC_W+W:W+1];
      q_d     = shifted[W:1];
      qm1_d   = shifted[0];
   end

   // Datapath registers: operands latched on accept so later a/b changes are ignored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q       <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         qm1_q     <= 1'b0;
         iter_q    <= '0;
         product_q <= '0;
      end else if (accept) begin
         m_q    <= {{(ACC_W-W){a[W-1]}}, a};
         acc_q  <= '0;
         q_q    <= b;
         qm1_q  <= 1'b0;
         iter_q <= '0;
      end else if (state_q == CALC) begin
         acc_q  <= acc_d;
         q_q    <= q_d;
         qm1_q  <= qm1_d;
         iter_q <= iter_q + ITER_W'(1);
         if (last_iter) begin
            product_q <= {acc_d[W-1:0], q_d};
         end
      end
   end

endmodule

// File: tb/tb_booth_seq_mult_8b.sv
// tb/tb_booth_seq_mult_8b.sv - randomized self-checking bench for booth_seq_mult_8b
module tb_booth_seq_mult_8b;

`ifdef BOOTH_RADIX4_EN
   localparam int N_EXP = 4;
`else
   localparam int N_EXP = 8;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   booth_seq_mult_8b dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_mult(input logic [7:0] x, input logic [7:0] y);
      int sx;
      int sy;
      int p;
      sx = $signed(x);
      sy = $signed(y);
      p  = sx * sy;
      return p[15:0];
   endfunction

   task automatic run_mult(input logic [7:0] ai, input logic [7:0] bi, input int bp,
                           input bit poke, input string tag);
      logic [15:0] exp_p;
      int cyc;
      exp_p = ref_mult(ai, bi);
      cyc = 0;
      while (!in_ready && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "/idle_in_ready"}, in_ready, 1);
      out_ready = (bp == 0);
      a = ai;
      b = bi;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      cyc = 0;
      do begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (!out_valid) check({tag, "/calc_in_ready"}, in_ready, 0);
         if (poke && cyc == 2) begin
            in_valid = 1'b1;
            a = 8'd1;
            b = 8'd1;
         end else begin
            in_valid = 1'b0;
         end
      end while (!out_valid && cyc < 30);
      in_valid = 1'b0;
      check({tag, "/latency"}, cyc, N_EXP);
      check({tag, "/product"}, product, exp_p);
      check({tag, "/done_in_ready"}, in_ready, 0);
      for (int i = 0; i < bp; i++) begin
         @(posedge clk);
         @(negedge clk);
         check({tag, "/bp_product"}, product, exp_p);
         check({tag, "/bp_out_valid"}, out_valid, 1);
         check({tag, "/bp_in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, "/ret_out_valid"}, out_valid, 0);
      check({tag, "/ret_in_ready"}, in_ready, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 8'd0;
      b         = 8'd0;
      repeat (2) @(negedge clk);
      check("rst/in_ready", in_ready, 1);
      check("rst/out_valid", out_valid, 0);
      check("rst/product", product, 0);
      rst = 1'b0;
      @(negedge clk);

      run_mult(8'd19, 8'd63, 0, 1'b0, "basic");
      check("basic/const", product, 16'h04AD);
      run_mult(8'h80, 8'h80, 0, 1'b0, "m128_m128");
      check("m128_m128/const", product, 16'h4000);
      run_mult(8'h80, 8'h7F, 0, 1'b0, "m128_p127");
      run_mult(8'h7F, 8'hFF, 0, 1'b0, "p127_m1");
      run_mult(8'h00, 8'hB3, 0, 1'b0, "zero_m77");
      run_mult(8'd19, 8'd63, 5, 1'b1, "bp_busy");

      // Reset during CALC iteration 3
      in_valid = 1'b1;
      a = 8'd19;
      b = 8'd63;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst/out_valid", out_valid, 0);
      check("midrst/product", product, 0);
      check("midrst/in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst/no_output", out_valid, 0);
      run_mult(8'd5, 8'hFD, 0, 1'b0, "after_rst");
      check("after_rst/const", product, 16'hFFF1);

      for (int k = 0; k < 40; k++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if ($urandom_range(0, 7) == 0) ra = 8'h80;
         if ($urandom_range(0, 7) == 0) rb = 8'h80;
         run_mult(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
